// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - SRAM frame read-out engine with byte-serialising stream output
//
// Purpose:
//   Reads word addresses 0..end of a captured frame from the camera SRAM read port.
//   Reading starts once the capture stage reports fetch_done. Each 32-bit word is
//   serialised as four bytes, least significant byte first. The result goes out on a
//   valid/ready byte stream toward the host link.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   start             one-cycle request to read out the current frame (ignored while busy)
//   fetch_done        capture stage level: frame is complete in SRAM
//   last_addr         last word address written by capture (clamped to MAX_ADDR)
//   s1_OE, s1_Addr    SRAM read enable (active low, one cycle per word) and word address
//   s1_RD             SRAM read data, valid RD_LAT cycles after s1_OE low
//   out_valid/out_ready/out_data/out_last   byte stream, out_last on the final byte
//   busy              high whenever a frame read-out is in progress
module frame_reader #(
  parameter int              AW         = 18,
  parameter logic [AW-1:0]   MAX_ADDR   = 18'h25800,
  parameter int              RD_LAT     = 2,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          fetch_done,
  input  logic [AW-1:0] last_addr,
  output logic          s1_OE,
  output logic [AW-1:0] s1_Addr,
  input  logic [31:0]   s1_RD,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READ, ST_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [AW-1:0]   end_addr_q, end_addr_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [31:0]     mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic [31:0]     word_q, word_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic            word_last_q, word_last_d;
  logic [AW-1:0]   pop_addr_q, pop_addr_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_last_q, out_last_d;

  logic            issue;
  logic            push;
  logic            pop;
  logic            accept;
  logic            out_free;
  logic [31:0]     head;
  int              inflight;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    end_addr_d  = end_addr_q;
    pipe_d      = pipe_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    word_d      = word_q;
    byte_idx_d  = byte_idx_q;
    word_last_d = word_last_q;
    pop_addr_d  = pop_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    // Credit: a read may only be issued if the FIFO has room for it and for
    // every word already travelling through the SRAM latency pipe.
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + int'(pipe_q[i]);
    end
    issue    = (state_q == ST_READ) && ((int'(count_q) + inflight) < FIFO_DEPTH);
    push     = pipe_q[RD_LAT-1];
    accept   = out_valid_q & out_ready;
    out_free = ~out_valid_q | out_ready;
    pop      = out_free && (byte_idx_q == 2'd0) && (count_q != '0);
    head     = mem_q[rd_ptr_q];

    // Frame sequencing
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_WAIT;
          rd_addr_d  = '0;
          pop_addr_d = '0;
        end
      end
      ST_WAIT: begin
        if (fetch_done) begin
          state_d    = ST_READ;
          rd_addr_d  = '0;
          end_addr_d = (last_addr > MAX_ADDR) ? MAX_ADDR : last_addr;
        end
      end
      ST_READ: begin
        if (issue) begin
          // Address stays parked at end so it never runs past the frame.
          if (rd_addr_q == end_addr_q) begin
            state_d = ST_DRAIN;
          end else begin
            rd_addr_d = rd_addr_q + AW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (accept && out_last_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // SRAM latency pipe: the tap marks the cycle s1_RD carries the issued word.
    pipe_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    // Word FIFO
    if (push) begin
      mem_d[wr_ptr_q] = s1_RD;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase

    // Unpacker: byte 0 goes straight from the FIFO head into the output
    // register, bytes 1..3 come from the held word, so there is no bubble
    // between words while the consumer keeps accepting.
    if (pop) begin
      word_d      = head;
      word_last_d = (pop_addr_q == end_addr_q);
      pop_addr_d  = pop_addr_q + AW'(1);
      byte_idx_d  = 2'd1;
      out_valid_d = 1'b1;
      out_data_d  = head[7:0];
      out_last_d  = 1'b0;
    end else if (out_free && (byte_idx_q != 2'd0)) begin
      byte_idx_d  = byte_idx_q + 2'd1;
      out_valid_d = 1'b1;
      out_last_d  = (byte_idx_q == 2'd3) && word_last_q;
      case (byte_idx_q)
        2'd1:    out_data_d = word_q[15:8];
        2'd2:    out_data_d = word_q[23:16];
        default: out_data_d = word_q[31:24];
      endcase
    end else if (accept) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      end_addr_q  <= '0;
      pipe_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      word_q      <= '0;
      byte_idx_q  <= '0;
      word_last_q <= 1'b0;
      pop_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      end_addr_q  <= end_addr_d;
      pipe_q      <= pipe_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      word_q      <= word_d;
      byte_idx_q  <= byte_idx_d;
      word_last_q <= word_last_d;
      pop_addr_q  <= pop_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign s1_OE     = ~issue;
  assign s1_Addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frame_reader.sv
// tb/tb_frame_reader.sv - scoreboard testbench for frame_reader
module tb_frame_reader;

  localparam int            AW         = 18;
  localparam int            RD_LAT     = 2;
  localparam int            FIFO_DEPTH = 4;
  // Reduced clamp so the clamp path is exercised within a short run.
  localparam logic [AW-1:0] MAX_A      = 18'h00040;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          fetch_done = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic          s1_OE;
  logic [AW-1:0] s1_Addr;
  logic [31:0]   s1_RD;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_data;
  logic          out_last;
  logic          busy;

  frame_reader #(
    .AW(AW), .MAX_ADDR(MAX_A), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .fetch_done(fetch_done),
    .last_addr(last_addr), .s1_OE(s1_OE), .s1_Addr(s1_Addr), .s1_RD(s1_RD),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM content: bytes of word a are a, a+0x10, a+0x20, a+0x30 (low byte first)
  function automatic logic [31:0] sram_word(input logic [AW-1:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'h30, b + 8'h20, b + 8'h10, b};
  endfunction

  // SRAM read port with RD_LAT cycles of latency
  logic [RD_LAT-1:0] sp_v = '0;
  logic [AW-1:0]     sp_addr [RD_LAT];
  always @(posedge clk) begin
    sp_v[0]    <= ~s1_OE;
    sp_addr[0] <= s1_Addr;
    for (int i = 1; i < RD_LAT; i++) begin
      sp_v[i]    <= sp_v[i-1];
      sp_addr[i] <= sp_addr[i-1];
    end
  end
  assign s1_RD = sp_v[RD_LAT-1] ? sram_word(sp_addr[RD_LAT-1]) : 32'hBAD0_BAD0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard and monitor state
  logic [8:0]    exp_q [$];
  logic [AW-1:0] exp_rd_addr = '0;
  logic [AW-1:0] last_rd_addr = '0;
  int            rd_count = 0;
  int            first_rd_cyc = -1;
  int            last_rd_cyc = -1;
  int            first_valid_cyc = -1;
  int            last_acc_cyc = -1;
  int            issued = 0;
  int            done_words = 0;
  int            acc_pos = 0;
  int            max_out = 0;
  logic          prev_stall = 1'b0;
  logic [7:0]    prev_data = '0;
  logic          prev_last = 1'b0;
  logic [7:0]    first_byte = '0;
  logic          first_seen = 1'b0;
  int            rand_mode = 0;

  always @(posedge clk) begin
    #1;
    out_ready = (rand_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (!s1_OE) begin
        check("rd_addr", 32'(s1_Addr), 32'(exp_rd_addr));
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        last_rd_cyc  = cyc;
        last_rd_addr = s1_Addr;
        exp_rd_addr  = exp_rd_addr + 1'b1;
        rd_count++;
        issued++;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) begin
        check("stall_hold", {23'd0, out_valid, out_last, out_data}, {23'd0, 1'b1, prev_last, prev_data});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %h expected none", {out_last, out_data});
        end else begin
          check("byte", {23'd0, out_last, out_data}, {23'd0, exp_q.pop_front()});
        end
        if (!first_seen) begin
          first_byte = out_data;
          first_seen = 1'b1;
        end
        acc_pos++;
        if (acc_pos == 4) begin
          acc_pos = 0;
          done_words++;
        end
        last_acc_cyc = cyc;
      end
      if (issued - done_words > max_out) max_out = issued - done_words;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_monitor();
    exp_rd_addr     = '0;
    rd_count        = 0;
    first_rd_cyc    = -1;
    last_rd_cyc     = -1;
    first_valid_cyc = -1;
    last_acc_cyc    = -1;
    issued          = 0;
    done_words      = 0;
    acc_pos         = 0;
    max_out         = 0;
    prev_stall      = 1'b0;
    first_seen      = 1'b0;
  endtask

  int start_cyc = 0;

  task automatic start_frame(input logic [AW-1:0] la);
    logic [AW-1:0] e;
    logic [31:0]   w;
    clear_monitor();
    e = (la > MAX_A) ? MAX_A : la;
    for (int a = 0; a <= int'(e); a++) begin
      w = sram_word(AW'(a));
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back({(a == int'(e)) && (b == 3), w[8*b +: 8]});
      end
    end
    last_addr = la;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle_in_time"}, 32'(n < budget), 32'd1);
    check({name, "_all_bytes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_cyc;
    int n;
    repeat (3) tick();
    check("rst_oe", 32'(s1_OE), 32'd1);
    check("rst_addr", 32'(s1_Addr), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // 1: four-word frame, consumer always ready
    fetch_done = 1'b1;
    start_frame(18'd3);
    wait_idle("t1", 200);
    check("t1_rd_latency", 32'(first_rd_cyc - start_cyc), 32'd2);
    check("t1_rd_consecutive", 32'(last_rd_cyc - first_rd_cyc), 32'd3);
    check("t1_rd_count", 32'(rd_count), 32'd4);
    check("t1_out_latency", 32'(first_valid_cyc - first_rd_cyc), 32'(RD_LAT + 2));
    check("t1_no_bubbles", 32'(last_acc_cyc - first_valid_cyc), 32'd15);
    check("t1_first_byte", 32'(first_byte), 32'h00);
    check("t1_busy_fall", 32'(cyc - last_acc_cyc), 32'd1);
    tick();

    // 2: start while capture not yet done
    fetch_done = 1'b0;
    start_frame(18'd5);
    repeat (50) tick();
    check("t2_no_reads", 32'(rd_count), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    fetch_done = 1'b1;
    fd_cyc = cyc;
    repeat (3) tick();
    check("t2_first_rd", 32'(first_rd_cyc - fd_cyc), 32'd1);
    wait_idle("t2", 300);
    tick();

    // 3: random back-pressure; fetch_done drops mid-frame
    rand_mode = 1;
    start_frame(18'd20);
    repeat (3) tick();
    fetch_done = 1'b0;
    wait_idle("t3", 3000);
    check("t3_rd_count", 32'(rd_count), 32'd21);
    check("t3_outstanding", 32'(max_out <= FIFO_DEPTH + 1), 32'd1);
    rand_mode = 0;
    fetch_done = 1'b1;
    repeat (2) tick();

    // 4: last_addr beyond clamp
    start_frame(18'h3ffff);
    wait_idle("t4", 3000);
    check("t4_final_addr", 32'(last_rd_addr), 32'(MAX_A));
    check("t4_rd_count", 32'(rd_count), 32'(int'(MAX_A) + 1));
    tick();

    // 5: single-word frame, extra start while busy is dropped
    start_frame(18'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("t5a", 200);
    check("t5a_rd_count", 32'(rd_count), 32'd1);
    repeat (5) tick();
    check("t5_start_not_queued", 32'(busy), 32'd0);
    start_frame(18'd1);
    check("t5b_busy", 32'(busy), 32'd1);
    wait_idle("t5b", 200);
    check("t5b_rd_count", 32'(rd_count), 32'd2);
    tick();

    // 6: asynchronous reset while streaming
    start_frame(18'd20);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("t6_valid_seen", 32'(n < 50), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_oe", 32'(s1_OE), 32'd1);
    check("t6_addr", 32'(s1_Addr), 32'd0);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_data", 32'(out_data), 32'd0);
    check("t6_last", 32'(out_last), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    start_frame(18'd2);
    wait_idle("t6", 300);
    check("t6_rd_count", 32'(rd_count), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
